// File: rtl/shift_pkg.sv
// ============================================================================
// Module   : shift_pkg
// Brief    : Mode constants and FSM state encodings for seq_shift_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

    localparam logic [1:0] MODE_LOGICAL = 2'b00;
    localparam logic [1:0] MODE_ARITH   = 2'b01;
    localparam logic [1:0] MODE_ROTATE  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module   : shift_step
// Brief    : Combinational single-bit shift/rotate step; reports the bit that
//            leaves the word. Mode 11 falls through to logical behaviour.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_to_right,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_next,
    output logic             o_out_bit
);

    logic w_fill;

    always_comb begin
        w_fill    = 1'b0;
        o_next    = i_value;
        o_out_bit = 1'b0;
        if (i_to_right) begin
            o_out_bit = i_value[0];
            if (i_mode == MODE_ARITH) begin
                w_fill = i_value[WIDTH-1];
            end else if (i_mode == MODE_ROTATE) begin
                w_fill = i_value[0];
            end
            o_next = {w_fill, i_value[WIDTH-1:1]};
        end else begin
            o_out_bit = i_value[WIDTH-1];
            if (i_mode == MODE_ROTATE) begin
                w_fill = i_value[WIDTH-1];
            end
            o_next = {i_value[WIDTH-2:0], w_fill};
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_shift_unit.sv
// ============================================================================
// Module   : seq_shift_unit
// Brief    : Sequential shifter, one bit per cycle. Optional sticky "lost"
//            output enabled by macro SEQ_SHIFT_LOST_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               to_right,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
`ifdef SEQ_SHIFT_LOST_EN
    output logic               lost,
`endif
    output logic [WIDTH-1:0]   result
);

    state_t             r_state;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_val;
    logic               r_dir;
    logic [1:0]         r_mode;
    logic [WIDTH-1:0]   w_next;
    logic               w_out_bit;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_value    (r_val),
        .i_to_right (r_dir),
        .i_mode     (r_mode),
        .o_next     (w_next),
        .o_out_bit  (w_out_bit)
    );

`ifndef SEQ_SHIFT_LOST_EN
    logic w_unused_out_bit;
    assign w_unused_out_bit = w_out_bit;
`endif

    // Working value lives in r_val; result is only written on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_val   <= '0;
            r_dir   <= 1'b0;
            r_mode  <= MODE_LOGICAL;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
`ifdef SEQ_SHIFT_LOST_EN
            lost    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= shamt;
                        r_val   <= operand;
                        r_dir   <= to_right;
                        r_mode  <= mode;
                        busy    <= 1'b1;
`ifdef SEQ_SHIFT_LOST_EN
                        lost    <= 1'b0;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_val <= w_next;
                        r_cnt <= r_cnt - 1'b1;
`ifdef SEQ_SHIFT_LOST_EN
                        if (w_out_bit && (r_mode != MODE_ROTATE)) begin
                            lost <= 1'b1;
                        end
`endif
                    end else begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        result  <= r_val;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
// ============================================================================
// Module   : tb_seq_shift_unit
// Brief    : Directed self-checking bench for seq_shift_unit (WIDTH=6).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_shift_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       to_right;
    logic [1:0] mode;
    logic [5:0] operand;
    logic [2:0] shamt;
    logic       busy;
    logic       done;
    logic [5:0] result;
`ifdef SEQ_SHIFT_LOST_EN
    logic       lost;
`endif

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [5:0] prev_res;

    seq_shift_unit #(
        .WIDTH   (6),
        .SHAMT_W (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .to_right (to_right),
        .mode     (mode),
        .operand  (operand),
        .shamt    (shamt),
        .busy     (busy),
        .done     (done),
`ifdef SEQ_SHIFT_LOST_EN
        .lost     (lost),
`endif
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launches one operation at a negedge, scrambles the inputs afterwards,
    // optionally pulses start again at cycle 'inject', and checks the result.
    task automatic run_op(input string tag, input logic [5:0] op, input logic dir,
                          input logic [1:0] md, input logic [2:0] sa,
                          input logic [5:0] exp_res, input logic exp_lost,
                          input int inject);
        int   cycles;
        logic busy_ok;
        logic hold_ok;
        logic seen;
        operand  = op;
        to_right = dir;
        mode     = md;
        shamt    = sa;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        operand  = ~op;
        to_right = ~dir;
        mode     = ~md;
        shamt    = ~sa;
        busy_ok  = busy;
        hold_ok  = (result === prev_res);
        cycles   = 0;
        seen     = 1'b0;
        while (cycles < 20 && !seen) begin
            @(negedge clk);
            cycles++;
            start = (cycles == inject);
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (result !== prev_res) hold_ok = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(cycles), 32'(sa) + 32'd1);
        chk({tag, " busy_while_running"}, 32'(busy_ok), 32'd1);
        chk({tag, " result_held_while_running"}, 32'(hold_ok), 32'd1);
        chk({tag, " result"}, 32'(result), 32'(exp_res));
        chk({tag, " busy_in_done"}, 32'(busy), 32'd1);
`ifdef SEQ_SHIFT_LOST_EN
        chk({tag, " lost"}, 32'(lost), 32'(exp_lost));
`else
        if (exp_lost === 1'bx) $display("note: unexpected X expectation");
`endif
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " idle_after"}, 32'(busy), 32'd0);
        chk({tag, " result_kept"}, 32'(result), 32'(exp_res));
        prev_res = exp_res;
    endtask

    initial begin
        logic seen_done;
        rst_n    = 1'b0;
        start    = 1'b0;
        to_right = 1'b0;
        mode     = 2'b00;
        operand  = 6'h00;
        shamt    = 3'd0;
        prev_res = 6'h00;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("lsl2",     6'b101100, 1'b0, 2'b00, 3'd2, 6'b110000, 1'b1, 0);
        run_op("asr3",     6'b101100, 1'b1, 2'b01, 3'd3, 6'b111101, 1'b1, 0);
        run_op("rol7",     6'b100001, 1'b0, 2'b10, 3'd7, 6'b000011, 1'b0, 0);
        run_op("sh0",      6'b010101, 1'b0, 2'b00, 3'd0, 6'b010101, 1'b0, 0);
        run_op("ign_start",6'b000001, 1'b0, 2'b00, 3'd5, 6'b100000, 1'b0, 2);
        run_op("lsr7_sat", 6'b111111, 1'b1, 2'b00, 3'd7, 6'b000000, 1'b1, 0);
        run_op("asr7_sat", 6'b100000, 1'b1, 2'b01, 3'd7, 6'b111111, 1'b1, 0);
        run_op("mode11",   6'b000011, 1'b1, 2'b11, 3'd1, 6'b000001, 1'b1, 0);
        run_op("ror2",     6'b000011, 1'b1, 2'b10, 3'd2, 6'b110000, 1'b0, 0);
        run_op("asl1",     6'b010000, 1'b0, 2'b01, 3'd1, 6'b100000, 1'b0, 0);

        // Abort a shamt-6 operation with a one-cycle reset during SHIFT.
        operand  = 6'b101010;
        to_right = 1'b0;
        mode     = 2'b00;
        shamt    = 3'd6;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort result", 32'(result), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
        end
        chk("abort no_done_after", 32'(seen_done), 32'd0);
        prev_res = 6'h00;

        run_op("recover",  6'b000111, 1'b1, 2'b10, 3'd1, 6'b100011, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
